// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: receiver resync sequencing, link liveness timeout and 2-entry packet buffer with drop counting.
// Optional duplicate-packet filter enabled by defining RX_LINK_DUP_FILTER_EN.
module rx_link_ctrl #(
    parameter int PKT_W          = 162,
    parameter int TIMEOUT_CYCLES = 130_000_000,
    parameter int RESYNC_CYCLES  = 16,
    parameter int CNT_W          = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [PKT_W-1:0] pkt_in,
    input  logic             pkt_ready_in,
    output logic             rx_rst_out,
    output logic [PKT_W-1:0] pkt_out,
    output logic             pkt_valid_out,
    input  logic             pkt_ack_in,
    output logic             link_up_out,
    output logic [CNT_W-1:0] drop_count_out
);
    localparam int IW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = RESYNC_CYCLES > 1 ? $clog2(RESYNC_CYCLES) : 1;

    typedef enum logic [1:0] {RESYNC, WAIT_FIRST, UP} state_t;

    state_t           state, state_nxt;
    logic [RW-1:0]    rs_cnt;
    logic [IW-1:0]    idle_cnt, idle_eff;
    logic             strobe, fresh, timeout, rs_done, push, pop, drop;
    logic [PKT_W-1:0] mem [2];
    logic             wp, rp;
    logic [1:0]       occ;

    assign strobe   = pkt_ready_in && state != RESYNC;
    // a strobe in the timeout cycle clears the count before the compare, so it wins
    assign idle_eff = strobe ? '0 : idle_cnt;
    assign timeout  = idle_eff == IW'(TIMEOUT_CYCLES - 1);
    assign rs_done  = rs_cnt == RW'(RESYNC_CYCLES - 1);
    assign pop      = pkt_valid_out && pkt_ack_in;
    assign push     = fresh && (occ != 2'd2 || pop);
    assign drop     = fresh && occ == 2'd2 && !pop;

`ifdef RX_LINK_DUP_FILTER_EN
    logic [PKT_W-1:0] last_pkt;
    logic             last_vld;

    assign fresh = strobe && !(last_vld && pkt_in == last_pkt);

    always_ff @(posedge clk_in) begin
        if (rst_in || (state_nxt == RESYNC && state != RESYNC)) begin
            last_vld <= 1'b0;
            last_pkt <= '0;
        end else if (push) begin
            last_vld <= 1'b1;
            last_pkt <= pkt_in;
        end
    end
`else
    assign fresh = strobe;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= RESYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == RESYNC) ? (rs_done ? WAIT_FIRST : RESYNC) :
                    timeout ? RESYNC : strobe ? UP : state;
    end

    always_comb begin
        rx_rst_out    = state == RESYNC;
        link_up_out   = state == UP;
        pkt_valid_out = occ != 2'd0;
        pkt_out       = mem[rp];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rs_cnt   <= '0;
            idle_cnt <= '0;
        end else begin
            rs_cnt   <= (state == RESYNC && !rs_done) ? rs_cnt + RW'(1) : '0;
            idle_cnt <= (state == RESYNC) ? '0 : timeout ? idle_eff : idle_eff + IW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem[0]         <= '0;
            mem[1]         <= '0;
            wp             <= 1'b0;
            rp             <= 1'b0;
            occ            <= 2'd0;
            drop_count_out <= '0;
        end else begin
            if (push) mem[wp] <= pkt_in;
            wp             <= wp ^ push;
            rp             <= rp ^ pop;
            occ            <= occ + {1'b0, push} - {1'b0, pop};
            drop_count_out <= drop_count_out + CNT_W'(drop && !(&drop_count_out));
        end
    end
endmodule

// File: tb/tb_rx_link_ctrl.sv
// tb_rx_link_ctrl: directed table-driven bench for rx_link_ctrl with TIMEOUT_CYCLES=100, RESYNC_CYCLES=4.
module tb_rx_link_ctrl;
    localparam int PKT_W = 162;
    localparam int T     = 100;
    localparam int R     = 4;

    logic             clk_in = 1'b0;
    logic             rst_in, pkt_ready_in, pkt_ack_in;
    logic [PKT_W-1:0] pkt_in;
    logic             rx_rst_out, pkt_valid_out, link_up_out;
    logic [PKT_W-1:0] pkt_out;
    logic [7:0]       drop_count_out;
    int               errors = 0;
    int               checks = 0;

    typedef struct {
        logic        rdy;
        logic [15:0] data;
        logic        ack;
        logic        v;
        logic [15:0] p;
        logic        chk_p;
        logic [7:0]  d;
    } vec_t;

    vec_t tbl [10];

    rx_link_ctrl #(.PKT_W(PKT_W), .TIMEOUT_CYCLES(T), .RESYNC_CYCLES(R), .CNT_W(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .pkt_in(pkt_in), .pkt_ready_in(pkt_ready_in),
        .rx_rst_out(rx_rst_out), .pkt_out(pkt_out), .pkt_valid_out(pkt_valid_out),
        .pkt_ack_in(pkt_ack_in), .link_up_out(link_up_out), .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // full/drop/ack sequence starting from an empty buffer in WAIT_FIRST
        tbl[0] = '{1'b1, 16'h1, 1'b0, 1'b1, 16'h1, 1'b1, 8'd0};
        tbl[1] = '{1'b1, 16'h2, 1'b0, 1'b1, 16'h1, 1'b1, 8'd0};
        tbl[2] = '{1'b1, 16'h3, 1'b0, 1'b1, 16'h1, 1'b1, 8'd1};
        tbl[3] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h2, 1'b1, 8'd1};
        tbl[4] = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 8'd1};
        tbl[5] = '{1'b1, 16'h1, 1'b0, 1'b1, 16'h1, 1'b1, 8'd1};
        tbl[6] = '{1'b1, 16'h2, 1'b0, 1'b1, 16'h1, 1'b1, 8'd1};
        tbl[7] = '{1'b1, 16'h4, 1'b1, 1'b1, 16'h2, 1'b1, 8'd1};
        tbl[8] = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h4, 1'b1, 8'd1};
        tbl[9] = '{1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 8'd1};

        rst_in = 1'b1; pkt_ready_in = 1'b0; pkt_ack_in = 1'b0; pkt_in = '0;
        tick;
        tick;
        chk("rst_valid", pkt_valid_out, 0);
        chk("rst_pkt", pkt_out, 0);
        chk("rst_drop", drop_count_out, 0);
        chk("rst_link", link_up_out, 0);
        chk("rst_rxrst", rx_rst_out, 1);
        rst_in = 1'b0;
        for (int i = 0; i < R; i++) begin
            chk("resync_hi", rx_rst_out, 1);
            chk("resync_link", link_up_out, 0);
            tick;
        end
        chk("resync_end", rx_rst_out, 0);
        chk("wait_link", link_up_out, 0);
        chk("wait_valid", pkt_valid_out, 0);

        for (int i = 0; i < 10; i++) begin
            pkt_ready_in = tbl[i].rdy;
            pkt_in       = PKT_W'(tbl[i].data);
            pkt_ack_in   = tbl[i].ack;
            tick;
            pkt_ready_in = 1'b0;
            pkt_ack_in   = 1'b0;
            chk($sformatf("tbl%0d_valid", i), pkt_valid_out, tbl[i].v);
            if (tbl[i].chk_p) chk($sformatf("tbl%0d_pkt", i), pkt_out, PKT_W'(tbl[i].p));
            chk($sformatf("tbl%0d_drop", i), drop_count_out, tbl[i].d);
            chk($sformatf("tbl%0d_link", i), link_up_out, 1);
            chk($sformatf("tbl%0d_rxrst", i), rx_rst_out, 0);
        end

        // strobe landing exactly on the timeout cycle keeps the link up
        pkt_ready_in = 1'b1; pkt_in = PKT_W'(16'h10);
        tick;
        pkt_ready_in = 1'b0; pkt_ack_in = 1'b1;
        tick;
        pkt_ack_in = 1'b0;
        chk("to_drain", pkt_valid_out, 0);
        repeat (T - 3) tick;
        chk("to_edge_link", link_up_out, 1);
        pkt_ready_in = 1'b1; pkt_in = PKT_W'(16'h11);
        tick;
        pkt_ready_in = 1'b0;
        chk("to_coinc_link", link_up_out, 1);
        chk("to_coinc_rxrst", rx_rst_out, 0);

        // silence after that strobe: resync begins exactly T cycles later
        pkt_ack_in = 1'b1;
        tick;
        pkt_ack_in = 1'b0;
        repeat (T - 3) tick;
        chk("to_pre_link", link_up_out, 1);
        chk("to_pre_rxrst", rx_rst_out, 0);
        tick;
        chk("to_link", link_up_out, 0);
        chk("to_rxrst", rx_rst_out, 1);

        pkt_ready_in = 1'b1;
        for (int i = 0; i < R; i++) begin
            pkt_in = PKT_W'(16'h20 + i);
            tick;
            chk("rs_valid", pkt_valid_out, 0);
            chk("rs_link", link_up_out, 0);
            chk("rs_drop", drop_count_out, 1);
            chk("rs_rxrst", rx_rst_out, (i < R - 1) ? 1'b1 : 1'b0);
        end
        pkt_ready_in = 1'b0;

        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
        repeat (R) tick;
        chk("dup_pre_drop", drop_count_out, 0);
        pkt_ready_in = 1'b1; pkt_in = PKT_W'(16'hABC);
        tick;
        tick;
        pkt_ready_in = 1'b0;
        chk("dup_link", link_up_out, 1);
        chk("dup_drop", drop_count_out, 0);
        chk("dup_valid", pkt_valid_out, 1);
        chk("dup_pkt", pkt_out, PKT_W'(16'hABC));
        pkt_ack_in = 1'b1;
        tick;
        pkt_ack_in = 1'b0;
`ifdef RX_LINK_DUP_FILTER_EN
        chk("dup_one_entry", pkt_valid_out, 0);
`else
        chk("dup_two_entries", pkt_valid_out, 1);
        chk("dup_second_pkt", pkt_out, PKT_W'(16'hABC));
`endif
        pkt_ack_in = 1'b1;
        tick;
        pkt_ack_in = 1'b0;
        chk("sat_empty", pkt_valid_out, 0);

        pkt_ready_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pkt_in = PKT_W'(16'h100 + i);
            tick;
        end
        pkt_ready_in = 1'b0;
        chk("sat_drop", drop_count_out, 255);
        chk("sat_valid", pkt_valid_out, 1);
        chk("sat_head", pkt_out, PKT_W'(16'h100));

        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
        chk("mid_rst_valid", pkt_valid_out, 0);
        chk("mid_rst_pkt", pkt_out, 0);
        chk("mid_rst_drop", drop_count_out, 0);
        chk("mid_rst_link", link_up_out, 0);
        chk("mid_rst_rxrst", rx_rst_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
